// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer that owns HI/LO for the pipelined MIPS core.
// Launches mult/multu/div/divu from EX, holds the unit busy for a fixed latency,
// then commits the pending result into HI/LO. Stalls ID for HI/LO users meanwhile.
//
// state | meaning
// IDLE  | nothing in flight; start-class op in EX launches, mthi/mtlo write HI/LO
// BUSY  | result parked in PH/PL, counter runs down to the HI/LO commit edge
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  output logic        stall_MD,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic is_start(input logic [31:0] ir);
    return (ir[31:26] == 6'b0) &&
           (ir[5:0] == F_MULT || ir[5:0] == F_MULTU || ir[5:0] == F_DIV || ir[5:0] == F_DIVU);
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    return is_start(ir) || ((ir[31:26] == 6'b0) &&
           (ir[5:0] == F_MFHI || ir[5:0] == F_MTHI || ir[5:0] == F_MFLO || ir[5:0] == F_MTLO));
  endfunction

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           busy_nxt;
  logic [31:0]    ph, pl, ph_nxt, pl_nxt, hi_nxt, lo_nxt;

  logic           start_e, ex_mthi, ex_mtlo, ex_div, ex_signed;
  logic [63:0]    op_a, op_b, prod;
  logic           dvd_neg, dvs_neg;
  logic [31:0]    dvd_mag, dvs_mag, q_mag, r_mag, quo, rem;
  logic [31:0]    res_hi, res_lo;

  logic           unused_ir_bits;
  assign unused_ir_bits = ^{IR_D[25:6], IR_E[25:6]};

  assign start_e   = (state == IDLE) && is_start(IR_E);
  assign ex_mthi   = (IR_E[31:26] == 6'b0) && (IR_E[5:0] == F_MTHI);
  assign ex_mtlo   = (IR_E[31:26] == 6'b0) && (IR_E[5:0] == F_MTLO);
  assign ex_div    = IR_E[1];
  assign ex_signed = ~IR_E[0];

  // Stall only HI/LO users in ID; held off while reset is asserted so all outputs read 0.
  assign stall_MD = rst_n && is_md(IR_D) && (busy || start_e);

  // Result datapath: sign/zero-extended 64-bit product, magnitude divide with sign fixup.
  // The magnitude form covers 0x80000000 / -1 naturally (quotient wraps to 0x80000000).
  always_comb begin
    op_a    = ex_signed ? {{32{RS_E[31]}}, RS_E} : {32'b0, RS_E};
    op_b    = ex_signed ? {{32{RT_E[31]}}, RT_E} : {32'b0, RT_E};
    prod    = op_a * op_b;
    dvd_neg = ex_signed && RS_E[31];
    dvs_neg = ex_signed && RT_E[31];
    dvd_mag = dvd_neg ? -RS_E : RS_E;
    dvs_mag = dvs_neg ? -RT_E : RT_E;
    q_mag   = (dvs_mag == 32'b0) ? 32'b0 : dvd_mag / dvs_mag;
    r_mag   = (dvs_mag == 32'b0) ? 32'b0 : dvd_mag % dvs_mag;
    quo     = (dvd_neg ^ dvs_neg) ? -q_mag : q_mag;
    rem     = dvd_neg ? -r_mag : r_mag;
    if (!ex_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (RT_E == 32'b0) begin
      res_hi = RS_E;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Next-state logic: launch, countdown, commit, and idle-time mthi/mtlo writes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ph_nxt    = ph;
    pl_nxt    = pl;
    hi_nxt    = HI;
    lo_nxt    = LO;
    case (state)
      IDLE: begin
        if (start_e) begin
          ph_nxt    = res_hi;
          pl_nxt    = res_lo;
          cnt_nxt   = ex_div ? DIV_LOAD : MULT_LOAD;
          state_nxt = BUSY;
          busy_nxt  = 1'b1;
        end else if (ex_mthi) begin
          hi_nxt = RS_E;
        end else if (ex_mtlo) begin
          lo_nxt = RS_E;
        end
      end
      BUSY: begin
        if (cnt == CNT_ONE) begin
          hi_nxt    = ph;
          lo_nxt    = pl;
          cnt_nxt   = '0;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      ph    <= '0;
      pl    <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      ph    <= ph_nxt;
      pl    <= pl_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: per-cycle check of md_ctrl against a time-based reference model
// driven through a small ID/EX pipeline model.
module tb_md_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_D, IR_E, RS_E, RT_E, HI, LO;
  logic        stall_MD, busy;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .IR_D(IR_D), .IR_E(IR_E), .RS_E(RS_E), .RT_E(RT_E),
    .stall_MD(stall_MD), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] rs;
    logic [31:0] rt;
  } instr_t;

  localparam instr_t NOP = '0;

  instr_t prog[$];
  instr_t id_i, ex_i;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: pending op is described by its start cycle and latency
  bit          m_pend;
  int          m_start, m_n;
  logic [31:0] m_hi, m_lo, m_ph, m_pl;

  function automatic instr_t mk(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    instr_t t;
    t.ir = {6'b0, 15'($urandom), 5'b0, f};
    t.rs = rs;
    t.rt = rt;
    return t;
  endfunction

  function automatic bit m_is_start(input logic [31:0] ir);
    return ir[31:26] == 6'b0 && ir[5:0] inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic bit m_is_md(input logic [31:0] ir);
    return ir[31:26] == 6'b0 &&
           ir[5:0] inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
  endfunction

  task automatic model_result(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (ir[5:0])
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32];
        lo = sp[31:0];
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      F_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          hi = sr[31:0];
          lo = sq[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_pend = 0; m_start = 0; m_n = 0;
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0;
    id_i = NOP; ex_i = NOP;
    prog.delete();
    cyc = 0;
  endtask

  // One pipeline cycle: drive, predict, check at negedge, advance model and pipeline.
  task automatic step();
    bit st, exp_stall, exp_busy;
    IR_D = id_i.ir; IR_E = ex_i.ir; RS_E = ex_i.rs; RT_E = ex_i.rt;
    if (m_pend && cyc == m_start + m_n + 1) begin
      m_hi = m_ph; m_lo = m_pl; m_pend = 0;
    end
    exp_busy  = m_pend;
    st        = !m_pend && m_is_start(ex_i.ir);
    exp_stall = m_is_md(id_i.ir) && (m_pend || st);
    @(negedge clk);
    checks++;
    if (stall_MD !== exp_stall) begin
      errors++; $display("FAIL stall_MD cyc=%0d got=%b exp=%b", cyc, stall_MD, exp_stall);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    checks++;
    if (HI !== m_hi) begin
      errors++; $display("FAIL HI cyc=%0d got=%h exp=%h", cyc, HI, m_hi);
    end
    checks++;
    if (LO !== m_lo) begin
      errors++; $display("FAIL LO cyc=%0d got=%h exp=%h", cyc, LO, m_lo);
    end
    if (st) begin
      m_pend = 1; m_start = cyc;
      m_n = ex_i.ir[1] ? DC : MC;
      model_result(ex_i.ir, ex_i.rs, ex_i.rt, m_ph, m_pl);
    end else if (!m_pend && m_is_md(ex_i.ir) && ex_i.ir[5:0] == F_MTHI) begin
      m_hi = ex_i.rs;
    end else if (!m_pend && m_is_md(ex_i.ir) && ex_i.ir[5:0] == F_MTLO) begin
      m_lo = ex_i.rs;
    end
    if (exp_stall) begin
      ex_i = NOP;
    end else begin
      ex_i = id_i;
      if (prog.size() > 0) id_i = prog.pop_front();
      else id_i = NOP;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((prog.size() > 0 || id_i != NOP || ex_i != NOP || m_pend) && n < limit) begin
      step(); n++;
    end
    step(); step();
    checks++;
    if (n >= limit) begin
      errors++; $display("FAIL drain_timeout got=%0d exp<%0d", n, limit);
    end
  endtask

  task automatic const_check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    IR_D = '0; IR_E = '0; RS_E = '0; RT_E = '0;
    #12;
    const_check("reset_stall", {31'b0, stall_MD}, 32'd0);
    const_check("reset_busy", {31'b0, busy}, 32'd0);
    const_check("reset_HI", HI, 32'd0);
    const_check("reset_LO", LO, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    // abort mid-BUSY: pending product must never reach HI/LO
    ex_i = mk(F_MULT, 32'd5, 32'd7);
    id_i = mk(F_MFLO, 32'd0, 32'd0);
    repeat (3) step();
    IR_E = ex_i.ir; IR_D = mk(F_MFLO, 0, 0).ir;
    IR_E = mk(F_MULT, 0, 0).ir;
    #2 rst_n = 1'b0;
    #1;
    const_check("abort_stall", {31'b0, stall_MD}, 32'd0);
    const_check("abort_busy", {31'b0, busy}, 32'd0);
    const_check("abort_HI", HI, 32'd0);
    const_check("abort_LO", LO, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    IR_E = '0; IR_D = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (MC + 4) step();
    const_check("abort_no_commit_HI", HI, 32'd0);
    const_check("abort_no_commit_LO", LO, 32'd0);
  endtask

  task automatic test_mult();
    ex_i = mk(F_MULT, 32'hFFFF_FFFE, 32'd3);
    drain(100);
    const_check("mult_HI", HI, 32'hFFFF_FFFF);
    const_check("mult_LO", LO, 32'hFFFF_FFFA);
    ex_i = mk(F_MULTU, 32'hFFFF_FFFE, 32'd3);
    drain(100);
    const_check("multu_HI", HI, 32'h0000_0002);
    const_check("multu_LO", LO, 32'hFFFF_FFFA);
  endtask

  task automatic test_div();
    ex_i = mk(F_DIV, 32'hFFFF_FFF9, 32'd2);
    id_i = mk(F_MFLO, 0, 0);
    drain(100);
    const_check("div_LO", LO, 32'hFFFF_FFFD);
    const_check("div_HI", HI, 32'hFFFF_FFFF);
    ex_i = mk(F_DIVU, 32'd7, 32'd0);
    drain(100);
    const_check("divu0_HI", HI, 32'h0000_0007);
    const_check("divu0_LO", LO, 32'hFFFF_FFFF);
    ex_i = mk(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(100);
    const_check("divovf_LO", LO, 32'h8000_0000);
    const_check("divovf_HI", HI, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    ex_i = mk(F_MULT, 32'd1000, 32'd3);
    id_i = mk(F_ADDU, 0, 0);
    repeat (3) prog.push_back(mk(F_ADDU, 0, 0));
    drain(100);
    ex_i = mk(F_MULT, 32'd6, 32'd7);
    id_i = mk(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain(100);
    const_check("b2b_HI", HI, 32'd0);
    const_check("b2b_LO", LO, 32'd1);
  endtask

  task automatic test_mthi();
    ex_i = mk(F_MTHI, 32'h1234_5678, 0);
    id_i = mk(F_MFHI, 0, 0);
    step();
    const_check("mthi_HI", HI, 32'h1234_5678);
    drain(100);
    // protocol violation: mtlo forced into EX while busy must be ignored
    ex_i = mk(F_MULT, 32'd9, 32'd11);
    step(); step();
    ex_i = mk(F_MTLO, 32'hDEAD_BEEF, 0);
    drain(100);
    const_check("mtlo_ignored_LO", LO, 32'd99);
    // start-class funct under a non-zero opcode is not an MD op
    ex_i.ir = {6'b001000, 20'h12345, F_MULT}; ex_i.rs = 32'd3; ex_i.rt = 32'd4;
    id_i.ir = {6'b001000, 20'h54321, F_MFLO};
    drain(100);
    const_check("nonzero_op_LO", LO, 32'd99);
  endtask

  task automatic test_random();
    logic [5:0] fl [9];
    logic [31:0] opv [2];
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_ADDU};
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: opv[k] = 32'd0;
          1: opv[k] = 32'h8000_0000;
          2: opv[k] = 32'hFFFF_FFFF;
          3: opv[k] = 32'($urandom_range(0, 20));
          default: opv[k] = $urandom;
        endcase
      end
      prog.push_back(mk(fl[$urandom_range(0, 8)], opv[0], opv[1]));
    end
    drain(5000);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_mthi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp<2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
